// File: rtl/sm83_fetch_if.sv
// Bus and handshake bundle between the SM83 fetch unit and its neighbours:
// memory bus, decode (instruction handshake), execute (operand requests,
// redirects) and the architectural PC readback.
interface sm83_fetch_if;
    // Core memory bus
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    // Execute -> fetch control
    logic        fetch_go;
    logic        opnd_req;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    // Fetch -> decode instruction handshake
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr;
    logic        instr_cb;
    logic [15:0] instr_pc;

    // Fetch -> execute immediate operand
    logic        opnd_valid;
    logic [7:0]  opnd_data;

    // Current PC (next byte to fetch)
    logic [15:0] pc;

    // Fetch unit side: drives the bus and the decode/execute results
    modport master (
        output mem_addr, mem_rd, instr_valid, instr, instr_cb, instr_pc,
               opnd_valid, opnd_data, pc,
        input  mem_rdata, mem_ack, fetch_go, opnd_req, redirect_valid,
               redirect_pc, instr_ready
    );

    // Environment side: memory, decode and execute
    modport slave (
        input  mem_addr, mem_rd, instr_valid, instr, instr_cb, instr_pc,
               opnd_valid, opnd_data, pc,
        output mem_rdata, mem_ack, fetch_go, opnd_req, redirect_valid,
               redirect_pc, instr_ready
    );
endinterface

// File: rtl/sm83_fetch.sv
// SM83 instruction fetch unit. Reads opcode bytes at PC, folds the 0xCB
// prefix into instr_cb, presents the opcode to decode with valid/ready,
// serves immediate-byte requests and applies PC redirects. A bus read
// cannot be aborted: a redirect during a read is parked as pending and
// applied when the read's ack arrives, with the read data discarded.
module sm83_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input logic          clk,
    input logic          rst,
    sm83_fetch_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        OP_RD,
        CB_RD,
        IMM_RD,
        HOLD
    } state_e;

    state_e      state_q;
    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic        mem_rd_q;
    logic        pend_q;
    logic [15:0] pend_pc_q;
    logic        instr_valid_q;
    logic [7:0]  instr_q;
    logic        instr_cb_q;
    logic [15:0] instr_pc_q;
    logic        opnd_valid_q;
    logic [7:0]  opnd_data_q;

    // A fresh redirect overrides one parked earlier.
    logic        redir_any;
    logic [15:0] redir_tgt;
    assign redir_any = bus.redirect_valid | pend_q;
    assign redir_tgt = bus.redirect_valid ? bus.redirect_pc : pend_pc_q;

    // Next PC: redirect target when one applies, +1 on an acked read
    // (wrapping naturally at 16 bits), otherwise unchanged.
    always_comb begin
        // NOTE: default first so every path assigns pc_d and no latch is inferred.
        pc_d = pc_q;
        unique case (state_q)
            IDLE: begin
                if (redir_any) pc_d = redir_tgt;
            end
            OP_RD, CB_RD, IMM_RD: begin
                if (bus.mem_ack) pc_d = redir_any ? redir_tgt : pc_q + 16'd1;
            end
            HOLD: begin
                if (bus.redirect_valid) pc_d = bus.redirect_pc;
            end
            default: pc_d = pc_q;
        endcase
    end

    // Fetch FSM with registered bus request and registered decode/operand outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            mem_rd_q      <= 1'b0;
            pend_q        <= 1'b0;
            pend_pc_q     <= 16'h0000;
            instr_valid_q <= 1'b0;
            instr_q       <= 8'h00;
            instr_cb_q    <= 1'b0;
            instr_pc_q    <= RESET_PC;
            opnd_valid_q  <= 1'b0;
            opnd_data_q   <= 8'h00;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            pc_q         <= pc_d;
            opnd_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    pend_q <= 1'b0;
                    if (redir_any) begin
                        state_q <= IDLE;
                    end else if (bus.fetch_go) begin
                        state_q    <= OP_RD;
                        mem_rd_q   <= 1'b1;
                        instr_pc_q <= pc_q;
                    end else if (bus.opnd_req) begin
                        state_q  <= IMM_RD;
                        mem_rd_q <= 1'b1;
                    end
                end
                OP_RD, CB_RD, IMM_RD: begin
                    if (bus.mem_ack) begin
                        pend_q <= 1'b0;
                        if (redir_any) begin
                            // Data of the in-flight read is dropped.
                            state_q  <= IDLE;
                            mem_rd_q <= 1'b0;
                        end else if (state_q == OP_RD && bus.mem_rdata == 8'hCB) begin
                            // Prefix byte: keep the request up for the second byte.
                            state_q <= CB_RD;
                        end else if (state_q == IMM_RD) begin
                            state_q      <= IDLE;
                            mem_rd_q     <= 1'b0;
                            opnd_data_q  <= bus.mem_rdata;
                            opnd_valid_q <= 1'b1;
                        end else begin
                            state_q       <= HOLD;
                            mem_rd_q      <= 1'b0;
                            instr_q       <= bus.mem_rdata;
                            instr_cb_q    <= (state_q == CB_RD);
                            instr_valid_q <= 1'b1;
                        end
                    end else if (bus.redirect_valid) begin
                        pend_q    <= 1'b1;
                        pend_pc_q <= bus.redirect_pc;
                    end
                end
                HOLD: begin
                    if (bus.redirect_valid || bus.instr_ready) begin
                        state_q       <= IDLE;
                        instr_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    mem_rd_q      <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr    = pc_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.pc          = pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_cb    = instr_cb_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.opnd_valid  = opnd_valid_q;
    assign bus.opnd_data   = opnd_data_q;

endmodule
